multi_port_memory_arbiter: RTL and testbench
============================================

# multi_port_memory_arbiter

Parametrised successor to the two-client memory access arbiter: it multiplexes `NumPorts` line-granular requesters onto the single external memory port. Requesters are fetch, load/store and future clients such as a page-table walker or DMA. It performs one transaction at a time and supports round-robin or fixed-priority selection. Requests, write data and read data are latched so that the memory side sees stable, registered signals. It sits between the cache/fetch units and the core's `memory*` top-level ports.

## Interface
Parameters:
- `NumPorts`, 2: number of requesters, 2..8.
- `AddrWidth`, 30: line address width.
- `LineWidth`, 128: line data width.
- `RoundRobin`, 1: 1 selects round-robin arbitration; 0 selects fixed priority, where the lowest index wins.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `reqEnable`  in  [NumPorts]  per-port request. Held high until that port's `reqDone`.
- `reqIsWrite`  in  [NumPorts]  1 = write line, 0 = read line.
- `reqAddr`  in  [NumPorts][AddrWidth]  line address.
- `reqWriteValue`  in  [NumPorts][LineWidth]  write data.
- `reqDone`  out  [NumPorts]  one-cycle completion pulse, one-hot.
- `reqReadValue`  out  LineWidth  read data. Valid while any `reqDone` is high; shared by all ports.
- `memEnable`  out  1  memory request, registered.
- `memIsWrite`  out  1  registered.
- `memAddr`  out  AddrWidth  registered.
- `memWriteValue`  out  LineWidth  registered.
- `memReadValue`  in  LineWidth  sampled when `memDone` is high.
- `memDone`  in  1  memory completion, single cycle.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If any `reqEnable` bit is set, pick a grant index `g`.
  - Latch `reqIsWrite[g]`, `reqAddr[g]` and `reqWriteValue[g]` into the `mem*` registers.
  - Set `memEnable` and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - `mem*` outputs are held constant.
  - On `memDone`: latch `memReadValue` into `reqReadValue` and go to DONE.
  - There is no timeout.
- DONE:
  - `memEnable` is 0 and `reqDone[g]` is 1 for this one cycle.
  - No arbitration takes place in this cycle, so a requester still holding `reqEnable` is not re-granted.
  - Next state is IDLE.
- Arbitration:
  - Round-robin: a pointer `p` of width clog2(NumPorts) (min 1) holds the highest-priority index. The search runs from `p` upward modulo `NumPorts`. On entering DONE, `p` becomes (g+1) mod NumPorts, so `NumPorts-1` wraps to 0.
  - Fixed: the lowest set index wins and `p` is unused.
- Boundary rules:
  - `memDone` outside ACCESS is ignored.
  - If `reqEnable[g]` drops during ACCESS, the transaction still completes and `reqDone[g]` still pulses.
  - If request inputs change during ACCESS, they are ignored because the latched values are used.
  - Write transactions also pulse `reqDone`. `reqReadValue` is then updated from `memReadValue` but carries no meaning.
  - Reset mid-ACCESS:
    - The next state is IDLE and `memEnable` is 0 in the cycle after the reset edge.
    - The memory model must tolerate an abandoned request.
    - No `reqDone` is issued.

## Timing
- Reset values:
  - State IDLE, `p`=0, `memEnable`=0, `memIsWrite`=0.
  - `memAddr`=0, `memWriteValue`=0.
  - `reqDone`=0, `reqReadValue`=0.
- A request sampled in IDLE at edge t drives `memEnable`=1 from t+1.
- `memDone` sampled at edge d gives DONE (`reqDone` pulse, `memEnable`=0) during cycle d+1.
- IDLE is reached at d+2. The earliest next `memEnable` is d+3.
- `memEnable` stays high continuously from grant until the cycle after `memDone`.
- All outputs are flop outputs; there are no combinational input-to-output paths.

## Structure
- Package `MemoryArbiterTypes` holds:
  - `ArbiterState` enum {IDLE, ACCESS, DONE}.
  - A localparam helper for pointer width.
- Sub-module `memory_arbiter_picker` is purely combinational:
  - Inputs: `reqEnable`, `p`, `RoundRobin`.
  - Outputs: `valid` and one-hot/index grant.
- The arbiter holds the state machine, the pointer and the data registers.

## Test plan
- Single read: NumPorts=2, port1 reads addr 0x10, memory returns 0xDEAD_BEEF after 3 cycles.
  - Expect `memEnable` for 4 cycles with `memAddr`=0x10.
  - Expect `reqDone`=2'b10 for one cycle with `reqReadValue`=0xDEAD_BEEF.
- Contention, round-robin: ports 0 and 1 request continuously, memDone latency 1.
  - Expect grants 0,1,0,1.
  - Expect `memEnable` high again exactly 2 cycles after each DONE.
- Fixed priority (`RoundRobin`=0): ports 0 and 1 request continuously.
  - Expect port 0 is granted every time.
  - Expect port 1 is granted only after port 0 deasserts.
- Pointer wrap: NumPorts=3, all ports requesting.
  - Expect grant order 0,1,2,0.
  - After a grant to 2, expect `p`=0.
- Write with request drop: port0 writes 0xA5A5 to 0x3 and drops `reqEnable` during ACCESS; the port input data changes afterwards.
  - Expect `memWriteValue` to stay 0xA5A5.
  - Expect `reqDone`=2'b01 after `memDone`.
- Reset mid-ACCESS: assert `rst` 2 cycles into a read.
  - Expect `memEnable`=0 in the cycle after the reset edge and no `reqDone`.
  - A later spurious `memDone` is ignored.

Source files
------------

// File: rtl/MemoryArbiterTypes.sv
// Shared types and helpers for the multi-port memory arbiter.
package MemoryArbiterTypes;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } ArbiterState;

   // Round-robin pointer width; a single-port build still gets one bit.
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/memory_arbiter_picker.sv
// Combinational grant selection: round-robin from pointer p, or lowest index first.
module memory_arbiter_picker
   import MemoryArbiterTypes::*;
#(
   parameter int unsigned NumPorts   = 2,
   parameter int unsigned RoundRobin = 1,
   parameter int unsigned PtrWidth   = ptr_width(NumPorts)
) (
   input  logic [NumPorts-1:0] reqEnable,
   input  logic [PtrWidth-1:0] p,
   output logic                valid,
   output logic [PtrWidth-1:0] grantIdx,
   output logic [NumPorts-1:0] grantOneHot
);

   always_comb begin
      int unsigned         start;
      int unsigned         idx;
      logic [PtrWidth-1:0] idx_w;
      valid       = 1'b0;
      grantIdx    = '0;
      grantOneHot = '0;
      idx         = 0;
      idx_w       = '0;
      // Fixed priority is a round-robin search that always starts at port 0.
      start       = (RoundRobin != 0) ? 32'(p) : 32'd0;
      for (int unsigned k = 0; k < NumPorts; k++) begin
         idx   = (start + k) % NumPorts;
         idx_w = PtrWidth'(idx);
         if (!valid && reqEnable[idx_w]) begin
            valid              = 1'b1;
            grantIdx           = idx_w;
            grantOneHot[idx_w] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/multi_port_memory_arbiter.sv
// Multiplexes NumPorts line requesters onto one external memory port, one
// transaction at a time, with all memory-side and completion outputs registered.
module multi_port_memory_arbiter
   import MemoryArbiterTypes::*;
#(
   parameter int unsigned NumPorts   = 2,
   parameter int unsigned AddrWidth  = 30,
   parameter int unsigned LineWidth  = 128,
   parameter int unsigned RoundRobin = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NumPorts-1:0]                 reqEnable,
   input  logic [NumPorts-1:0]                 reqIsWrite,
   input  logic [NumPorts-1:0][AddrWidth-1:0]  reqAddr,
   input  logic [NumPorts-1:0][LineWidth-1:0]  reqWriteValue,
   output logic [NumPorts-1:0]                 reqDone,
   output logic [LineWidth-1:0]                reqReadValue,
   output logic                                memEnable,
   output logic                                memIsWrite,
   output logic [AddrWidth-1:0]                memAddr,
   output logic [LineWidth-1:0]                memWriteValue,
   input  logic [LineWidth-1:0]                memReadValue,
   input  logic                                memDone
);

   localparam int unsigned PtrWidth = ptr_width(NumPorts);

   ArbiterState         state_q, state_d;
   logic [PtrWidth-1:0] ptr_q, ptr_d;
   logic [PtrWidth-1:0] grant_idx_q, grant_idx_d;
   logic [NumPorts-1:0] grant_oh_q, grant_oh_d;
   logic [NumPorts-1:0] req_done_q, req_done_d;
   logic [LineWidth-1:0] read_value_q, read_value_d;
   logic                mem_enable_q, mem_enable_d;
   logic                mem_is_write_q, mem_is_write_d;
   logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
   logic [LineWidth-1:0] mem_write_value_q, mem_write_value_d;

   logic                pick_valid;
   logic [PtrWidth-1:0] pick_idx;
   logic [NumPorts-1:0] pick_oh;

   memory_arbiter_picker #(
      .NumPorts   (NumPorts),
      .RoundRobin (RoundRobin),
      .PtrWidth   (PtrWidth)
   ) u_picker (
      .reqEnable   (reqEnable),
      .p           (ptr_q),
      .valid       (pick_valid),
      .grantIdx    (pick_idx),
      .grantOneHot (pick_oh)
   );

   always_comb begin
      state_d           = state_q;
      ptr_d             = ptr_q;
      grant_idx_d       = grant_idx_q;
      grant_oh_d        = grant_oh_q;
      req_done_d        = '0;
      read_value_d      = read_value_q;
      mem_enable_d      = mem_enable_q;
      mem_is_write_d    = mem_is_write_q;
      mem_addr_d        = mem_addr_q;
      mem_write_value_d = mem_write_value_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_idx_d       = pick_idx;
               grant_oh_d        = pick_oh;
               mem_enable_d      = 1'b1;
               mem_is_write_d    = reqIsWrite[pick_idx];
               mem_addr_d        = reqAddr[pick_idx];
               mem_write_value_d = reqWriteValue[pick_idx];
               state_d           = ACCESS;
            end
         end
         ACCESS: begin
            // Completion is tied to the latched grant, not the live request line.
            if (memDone) begin
               read_value_d = memReadValue;
               mem_enable_d = 1'b0;
               req_done_d   = grant_oh_q;
               if (RoundRobin != 0) begin
                  ptr_d = (grant_idx_q == PtrWidth'(NumPorts - 1)) ? '0 : grant_idx_q + 1'b1;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= IDLE;
         ptr_q             <= '0;
         grant_idx_q       <= '0;
         grant_oh_q        <= '0;
         req_done_q        <= '0;
         read_value_q      <= '0;
         mem_enable_q      <= 1'b0;
         mem_is_write_q    <= 1'b0;
         mem_addr_q        <= '0;
         mem_write_value_q <= '0;
      end else begin
         state_q           <= state_d;
         ptr_q             <= ptr_d;
         grant_idx_q       <= grant_idx_d;
         grant_oh_q        <= grant_oh_d;
         req_done_q        <= req_done_d;
         read_value_q      <= read_value_d;
         mem_enable_q      <= mem_enable_d;
         mem_is_write_q    <= mem_is_write_d;
         mem_addr_q        <= mem_addr_d;
         mem_write_value_q <= mem_write_value_d;
      end
   end

   assign reqDone       = req_done_q;
   assign reqReadValue  = read_value_q;
   assign memEnable     = mem_enable_q;
   assign memIsWrite    = mem_is_write_q;
   assign memAddr       = mem_addr_q;
   assign memWriteValue = mem_write_value_q;

endmodule

// File: tb/tb_multi_port_memory_arbiter.sv
// Bench for multi_port_memory_arbiter: directed scenarios on 2-port builds and a
// randomized run of a 3-port round-robin build against a transaction-level model.
module tb_multi_port_memory_arbiter;

   localparam int unsigned AW  = 30;
   localparam int unsigned LW  = 128;
   localparam int unsigned AW3 = 16;
   localparam int unsigned LW3 = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // 2-port round-robin build
   logic [1:0]         a_en, a_we, a_done;
   logic [1:0][AW-1:0] a_addr;
   logic [1:0][LW-1:0] a_wd;
   logic [LW-1:0]      a_rv, a_mwd, a_mrv;
   logic [AW-1:0]      a_maddr;
   logic               a_men, a_mwe, a_mdone;

   // 2-port fixed-priority build
   logic [1:0]         f_en, f_we, f_done;
   logic [1:0][AW-1:0] f_addr;
   logic [1:0][LW-1:0] f_wd;
   logic [LW-1:0]      f_rv, f_mwd, f_mrv;
   logic [AW-1:0]      f_maddr;
   logic               f_men, f_mwe, f_mdone;

   // 3-port round-robin build
   logic [2:0]          r_en, r_we, r_done;
   logic [2:0][AW3-1:0] r_addr;
   logic [2:0][LW3-1:0] r_wd;
   logic [LW3-1:0]      r_rv, r_mwd, r_mrv;
   logic [AW3-1:0]      r_maddr;
   logic                r_men, r_mwe, r_mdone;

   multi_port_memory_arbiter #(
      .NumPorts(2), .AddrWidth(AW), .LineWidth(LW), .RoundRobin(1)
   ) dut_a (
      .clk(clk), .rst(rst), .reqEnable(a_en), .reqIsWrite(a_we), .reqAddr(a_addr),
      .reqWriteValue(a_wd), .reqDone(a_done), .reqReadValue(a_rv), .memEnable(a_men),
      .memIsWrite(a_mwe), .memAddr(a_maddr), .memWriteValue(a_mwd),
      .memReadValue(a_mrv), .memDone(a_mdone)
   );

   multi_port_memory_arbiter #(
      .NumPorts(2), .AddrWidth(AW), .LineWidth(LW), .RoundRobin(0)
   ) dut_f (
      .clk(clk), .rst(rst), .reqEnable(f_en), .reqIsWrite(f_we), .reqAddr(f_addr),
      .reqWriteValue(f_wd), .reqDone(f_done), .reqReadValue(f_rv), .memEnable(f_men),
      .memIsWrite(f_mwe), .memAddr(f_maddr), .memWriteValue(f_mwd),
      .memReadValue(f_mrv), .memDone(f_mdone)
   );

   multi_port_memory_arbiter #(
      .NumPorts(3), .AddrWidth(AW3), .LineWidth(LW3), .RoundRobin(1)
   ) dut_r (
      .clk(clk), .rst(rst), .reqEnable(r_en), .reqIsWrite(r_we), .reqAddr(r_addr),
      .reqWriteValue(r_wd), .reqDone(r_done), .reqReadValue(r_rv), .memEnable(r_men),
      .memIsWrite(r_mwe), .memAddr(r_maddr), .memWriteValue(r_mwd),
      .memReadValue(r_mrv), .memDone(r_mdone)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Spec rule: first requester at or above p, wrapping modulo the port count.
   function automatic int rr_pick(input logic [2:0] en, input int p, input int n);
      for (int k = 0; k < n; k++) begin
         if (en[(p + k) % n]) return (p + k) % n;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      a_en = '0; a_we = '0; a_addr = '0; a_wd = '0; a_mrv = '0; a_mdone = 1'b0;
      f_en = '0; f_we = '0; f_addr = '0; f_wd = '0; f_mrv = '0; f_mdone = 1'b0;
      r_en = '0; r_we = '0; r_addr = '0; r_wd = '0; r_mrv = '0; r_mdone = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({a_men, a_mwe, a_maddr, a_mwd, a_done, a_rv} !== '0)
         $display("FAIL reset_a: got men=%b mwe=%b addr=%h wd=%h done=%b rv=%h, want all 0",
                  a_men, a_mwe, a_maddr, a_mwd, a_done, a_rv);
      else n_pass++;
      n_checks++;
      if ({f_men, f_done, f_rv, r_men, r_done, r_rv, r_maddr} !== '0)
         $display("FAIL reset_fr: got f_men=%b f_done=%b r_men=%b r_done=%b r_addr=%h, want 0",
                  f_men, f_done, r_men, r_done, r_maddr);
      else n_pass++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      int hi_cycles = 0;
      a_en = 2'b10; a_we = 2'b00; a_addr[1] = AW'(32'h10);
      tick();
      for (int c = 0; c < 4; c++) begin
         if (a_men === 1'b1 && a_maddr === AW'(32'h10) && a_mwe === 1'b0) hi_cycles++;
         if (c == 3) begin
            a_mdone = 1'b1;
            a_mrv   = LW'(32'hDEAD_BEEF);
         end else begin
            tick();
         end
      end
      n_checks++;
      if (hi_cycles !== 4)
         $display("FAIL single_read_enable: memEnable@0x10 for %0d cycles, want 4", hi_cycles);
      else n_pass++;
      tick();
      a_mdone = 1'b0;
      n_checks++;
      if ({a_men, a_done, a_rv} !== {1'b0, 2'b10, LW'(32'hDEAD_BEEF)})
         $display("FAIL single_read_done: men=%b done=%b rv=%h, want 0 10 deadbeef",
                  a_men, a_done, a_rv);
      else n_pass++;
      a_en = 2'b00;
      tick();
      n_checks++;
      if ({a_men, a_done} !== 3'b000)
         $display("FAIL single_read_pulse: men=%b done=%b, want 0 00", a_men, a_done);
      else n_pass++;
   endtask

   task automatic test_contention_rr();
      int ptr = 0;
      int g;
      logic [LW-1:0] rv;
      a_en = 2'b11; a_we = 2'b00;
      a_addr[0] = AW'(32'h100); a_addr[1] = AW'(32'h200);
      tick();
      for (int t = 0; t < 4; t++) begin
         g = rr_pick(3'(a_en), ptr, 2);
         n_checks++;
         if ({a_men, a_maddr} !== {1'b1, a_addr[g]})
            $display("FAIL rr_grant%0d: men=%b addr=%h, want 1 %h", t, a_men, a_maddr, a_addr[g]);
         else n_pass++;
         rv = {$urandom, $urandom, $urandom, $urandom};
         a_mdone = 1'b1; a_mrv = rv;
         tick();
         a_mdone = 1'b0;
         ptr = (g + 1) % 2;
         n_checks++;
         if ({a_men, a_done, a_rv} !== {1'b0, 2'(1 << g), rv})
            $display("FAIL rr_done%0d: men=%b done=%b rv=%h, want 0 %b %h",
                     t, a_men, a_done, a_rv, 2'(1 << g), rv);
         else n_pass++;
         if (t == 3) a_en = 2'b00;
         tick();
         n_checks++;
         if ({a_men, a_done} !== 3'b000)
            $display("FAIL rr_gap%0d: men=%b done=%b, want 0 00", t, a_men, a_done);
         else n_pass++;
         tick();
      end
      n_checks++;
      if (a_men !== 1'b0) $display("FAIL rr_quiet: men=%b, want 0", a_men);
      else n_pass++;
   endtask

   task automatic test_fixed_priority();
      int want;
      f_en = 2'b11; f_we = 2'b00;
      f_addr[0] = AW'(32'h1); f_addr[1] = AW'(32'h2);
      tick();
      for (int t = 0; t < 4; t++) begin
         want = (t < 3) ? 0 : 1;
         n_checks++;
         if ({f_men, f_maddr} !== {1'b1, f_addr[want]})
            $display("FAIL fixed_grant%0d: men=%b addr=%h, want 1 %h",
                     t, f_men, f_maddr, f_addr[want]);
         else n_pass++;
         f_mdone = 1'b1;
         tick();
         f_mdone = 1'b0;
         n_checks++;
         if ({f_men, f_done} !== {1'b0, 2'(1 << want)})
            $display("FAIL fixed_done%0d: men=%b done=%b, want 0 %b",
                     t, f_men, f_done, 2'(1 << want));
         else n_pass++;
         if (t == 2) f_en = 2'b10;
         if (t == 3) f_en = 2'b00;
         tick();
         tick();
      end
   endtask

   task automatic test_write_drop();
      a_en = 2'b01; a_we = 2'b01; a_addr[0] = AW'(32'h3); a_wd[0] = LW'(32'hA5A5);
      tick();
      n_checks++;
      if ({a_men, a_mwe, a_maddr, a_mwd} !== {2'b11, AW'(32'h3), LW'(32'hA5A5)})
         $display("FAIL write_grant: men=%b mwe=%b addr=%h wd=%h, want 1 1 3 a5a5",
                  a_men, a_mwe, a_maddr, a_mwd);
      else n_pass++;
      a_en = 2'b00; a_we = 2'b00; a_addr[0] = AW'(32'h7); a_wd[0] = LW'(32'h5A5A);
      for (int c = 0; c < 2; c++) begin
         tick();
         n_checks++;
         if ({a_men, a_mwe, a_maddr, a_mwd} !== {2'b11, AW'(32'h3), LW'(32'hA5A5)})
            $display("FAIL write_hold%0d: men=%b mwe=%b addr=%h wd=%h, want 1 1 3 a5a5",
                     c, a_men, a_mwe, a_maddr, a_mwd);
         else n_pass++;
      end
      a_mdone = 1'b1;
      tick();
      a_mdone = 1'b0;
      n_checks++;
      if ({a_men, a_done} !== 3'b001)
         $display("FAIL write_done: men=%b done=%b, want 0 01", a_men, a_done);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid_access();
      a_en = 2'b10; a_we = 2'b00; a_addr[1] = AW'(32'h44);
      tick();
      n_checks++;
      if ({a_men, a_maddr} !== {1'b1, AW'(32'h44)})
         $display("FAIL rstmid_grant: men=%b addr=%h, want 1 44", a_men, a_maddr);
      else n_pass++;
      tick();
      tick();
      rst = 1'b1; a_en = 2'b00;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({a_men, a_done, a_maddr} !== '0)
         $display("FAIL rstmid_abort: men=%b done=%b addr=%h, want 0 00 0",
                  a_men, a_done, a_maddr);
      else n_pass++;
      a_mdone = 1'b1; a_mrv = '1;
      tick();
      a_mdone = 1'b0;
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if ({a_men, a_done, a_rv} !== '0)
            $display("FAIL rstmid_spurious%0d: men=%b done=%b rv=%h, want 0 00 0",
                     c, a_men, a_done, a_rv);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_pointer_wrap();
      int order [4] = '{0, 1, 2, 0};
      r_en = 3'b111; r_we = 3'b000;
      r_addr[0] = AW3'(16'h10); r_addr[1] = AW3'(16'h11); r_addr[2] = AW3'(16'h12);
      tick();
      for (int t = 0; t < 4; t++) begin
         n_checks++;
         if ({r_men, r_maddr} !== {1'b1, r_addr[order[t]]})
            $display("FAIL wrap_grant%0d: men=%b addr=%h, want 1 %h",
                     t, r_men, r_maddr, r_addr[order[t]]);
         else n_pass++;
         r_mdone = 1'b1;
         tick();
         r_mdone = 1'b0;
         if (t == 3) r_en = 3'b000;
         tick();
         tick();
      end
   endtask

   task automatic test_random_traffic();
      int            phase = 0;
      int            ptr = 0;
      int            g = 0;
      int            lat = -1;
      logic [2:0]    pre_en, pre_we;
      logic [2:0][AW3-1:0] pre_addr;
      logic [2:0][LW3-1:0] pre_wd;
      logic          pre_mdone;
      logic [LW3-1:0] pre_mrv;
      logic          e_we = 1'b0;
      logic [AW3-1:0] e_addr = '0;
      logic [LW3-1:0] e_wd = '0;
      logic [LW3-1:0] e_rv = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         pre_en = r_en; pre_we = r_we; pre_addr = r_addr; pre_wd = r_wd;
         pre_mdone = r_mdone; pre_mrv = r_mrv;
         tick();
         if (phase == 0) begin
            if (pre_en != 3'b000) begin
               g = rr_pick(pre_en, ptr, 3);
               e_we = pre_we[g]; e_addr = pre_addr[g]; e_wd = pre_wd[g];
               phase = 1;
               n_checks++;
               if ({r_men, r_done, r_mwe, r_maddr, r_mwd} !== {1'b1, 3'b000, e_we, e_addr, e_wd})
                  $display("FAIL rand_grant@%0d: men=%b done=%b we=%b addr=%h wd=%h, want 1 000 %b %h %h (port %0d)",
                           cyc, r_men, r_done, r_mwe, r_maddr, r_mwd, e_we, e_addr, e_wd, g);
               else n_pass++;
            end else begin
               n_checks++;
               if ({r_men, r_done} !== 4'b0000)
                  $display("FAIL rand_idle@%0d: men=%b done=%b, want 0 000", cyc, r_men, r_done);
               else n_pass++;
            end
         end else if (phase == 1) begin
            if (pre_mdone) begin
               e_rv = pre_mrv;
               phase = 2;
               ptr = (g + 1) % 3;
               n_checks++;
               if ({r_men, r_done, r_rv} !== {1'b0, 3'(1 << g), e_rv})
                  $display("FAIL rand_done@%0d: men=%b done=%b rv=%h, want 0 %b %h",
                           cyc, r_men, r_done, r_rv, 3'(1 << g), e_rv);
               else n_pass++;
            end else begin
               n_checks++;
               if ({r_men, r_done, r_mwe, r_maddr, r_mwd} !== {1'b1, 3'b000, e_we, e_addr, e_wd})
                  $display("FAIL rand_hold@%0d: men=%b done=%b we=%b addr=%h wd=%h, want 1 000 %b %h %h",
                           cyc, r_men, r_done, r_mwe, r_maddr, r_mwd, e_we, e_addr, e_wd);
               else n_pass++;
            end
         end else begin
            phase = 0;
            n_checks++;
            if ({r_men, r_done} !== 4'b0000)
               $display("FAIL rand_after_done@%0d: men=%b done=%b, want 0 000", cyc, r_men, r_done);
            else n_pass++;
         end

         // Memory side: random latency while busy, occasional stray memDone otherwise.
         r_mrv = $urandom;
         if (phase == 1) begin
            if (lat < 0) lat = int'($urandom_range(0, 3));
            if (lat == 0) begin
               r_mdone = 1'b1;
               lat = -1;
            end else begin
               r_mdone = 1'b0;
               lat--;
            end
         end else begin
            r_mdone = ($urandom_range(0, 9) == 0);
            lat = -1;
         end

         for (int i = 0; i < 3; i++) begin
            r_we[i]   = $urandom_range(0, 1) == 1;
            r_addr[i] = AW3'($urandom);
            r_wd[i]   = $urandom;
            if (phase == 2 && g == i) r_en[i] = 1'b0;
            else if (phase == 1 && g == i) begin
               if (r_en[i] && $urandom_range(0, 7) == 0) r_en[i] = 1'b0;
            end else if (!r_en[i] && $urandom_range(0, 2) == 0) r_en[i] = 1'b1;
         end
      end
      r_en = '0; r_mdone = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_contention_rr();
      test_fixed_priority();
      test_write_drop();
      test_reset_mid_access();
      test_pointer_wrap();
      test_random_traffic();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
